// File: rtl/lcd_pixel_writer_pkg.sv
// rtl/lcd_pixel_writer_pkg.sv - shared constants and types for the LCD pixel writer
package lcd_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [1:0] {
        BYTE_IDLE = 2'd0,
        BYTE_LOW  = 2'd1,
        BYTE_HIGH = 2'd2
    } byte_state_t;

    typedef struct packed {
        logic [7:0]  x;
        logic [8:0]  y;
        logic [15:0] color;
    } pixel_t;

    function automatic logic is_clipped(input pixel_t p, input int scr_w, input int scr_h);
        return ({2'b00, p.x} >= 10'(scr_w)) || ({1'b0, p.y} >= 10'(scr_h));
    endfunction

endpackage

// File: rtl/lcd_bus_byte.sv
// rtl/lcd_bus_byte.sv - one 8080 bus write: data/dc set up at the low edge, wr_n low then high
module lcd_bus_byte
    import lcd_pkg::*;
#(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    input  logic       i_dc,
    output logic [7:0] o_d,
    output logic       o_dc,
    output logic       o_wr_n,
    output logic       o_done
);

    localparam int MAX_CYC = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] LOW_LAST  = CW'(WR_LOW_CYC - 1);
    localparam logic [CW-1:0] HIGH_LAST = CW'(WR_HIGH_CYC - 1);

    byte_state_t   r_state;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_d;
    logic          r_dc;
    logic          r_wr_n;

    // done is combinational so the next byte can start on the very edge the high phase ends
    assign o_done = (r_state == BYTE_HIGH) && (r_cnt == HIGH_LAST);
    assign o_d    = r_d;
    assign o_dc   = r_dc;
    assign o_wr_n = r_wr_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= BYTE_IDLE;
            r_cnt   <= '0;
            r_d     <= 8'h00;
            r_dc    <= 1'b1;
            r_wr_n  <= 1'b1;
        end else if (i_start) begin
            r_state <= BYTE_LOW;
            r_cnt   <= '0;
            r_d     <= i_byte;
            r_dc    <= i_dc;
            r_wr_n  <= 1'b0;
        end else begin
            case (r_state)
                BYTE_LOW: begin
                    if (r_cnt == LOW_LAST) begin
                        r_state <= BYTE_HIGH;
                        r_cnt   <= '0;
                        r_wr_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                BYTE_HIGH: begin
                    if (r_cnt == HIGH_LAST) begin
                        r_state <= BYTE_IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= BYTE_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/lcd_pixel_writer.sv
// rtl/lcd_pixel_writer.sv - pixel writes to ILI9341 CASET/PASET/RAMWR byte stream with window cache
module lcd_pixel_writer
    import lcd_pkg::*;
#(
    parameter int WR_LOW_CYC  = 2,
    parameter int WR_HIGH_CYC = 2,
    parameter int SCREEN_W    = 240,
    parameter int SCREEN_H    = 320
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        en_i,
    input  logic [7:0]  px_x_i,
    input  logic [8:0]  px_y_i,
    input  logic [15:0] px_color_i,
    input  logic        px_req_i,
    output logic        px_ack_o,
    output logic        busy_o,
    output logic [7:0]  lcd_d_o,
    output logic        lcd_dc_o,
    output logic        lcd_wr_n_o,
    output logic        lcd_cs_n_o
);

    localparam logic [3:0] ST_IDLE  = 4'd0;
    localparam logic [3:0] ST_LOAD  = 4'd1;
    localparam logic [3:0] ST_CMD_X = 4'd2;
    localparam logic [3:0] ST_ARG_X = 4'd3;
    localparam logic [3:0] ST_CMD_Y = 4'd4;
    localparam logic [3:0] ST_ARG_Y = 4'd5;
    localparam logic [3:0] ST_CMD_W = 4'd6;
    localparam logic [3:0] ST_COL_H = 4'd7;
    localparam logic [3:0] ST_COL_L = 4'd8;

    logic       r_hold_full;
    pixel_t     r_hold;
    pixel_t     r_work;
    logic       r_ack;
    logic [3:0] r_state;
    logic [1:0] r_arg_idx;
    logic [7:0] r_last_x;
    logic [8:0] r_last_y;
    logic       r_xv;
    logic       r_yv;
    logic       r_cs_n;

    pixel_t     w_in_px;
    logic       w_accept;
    logic       w_clip;
    logic       w_need_x;
    logic       w_need_y;
    logic       w_done;
    logic       w_start;
    logic [3:0] w_next_state;
    logic [1:0] w_next_idx;
    logic       w_set_x;
    logic       w_set_y;
    logic [7:0] w_byte;
    logic       w_dc;

    assign w_in_px  = '{x: px_x_i, y: px_y_i, color: px_color_i};
    assign w_accept = en_i && px_req_i && !r_hold_full && !r_ack;
    assign w_clip   = is_clipped(w_in_px, SCREEN_W, SCREEN_H);
    assign w_need_x = !(r_xv && ({1'b0, r_work.x} == {1'b0, r_last_x}));
    assign w_need_y = !(r_yv && (r_work.y == r_last_y));

    always_comb begin
        w_start      = 1'b0;
        w_next_state = r_state;
        w_next_idx   = r_arg_idx;
        w_set_x      = 1'b0;
        w_set_y      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_hold_full) w_next_state = ST_LOAD;
            end
            ST_LOAD: begin
                w_start      = 1'b1;
                w_next_idx   = 2'd0;
                w_next_state = w_need_x ? ST_CMD_X : (w_need_y ? ST_CMD_Y : ST_CMD_W);
            end
            ST_CMD_X: begin
                if (w_done) begin
                    w_start      = 1'b1;
                    w_next_state = ST_ARG_X;
                    w_next_idx   = 2'd0;
                end
            end
            ST_ARG_X: begin
                if (w_done) begin
                    w_start = 1'b1;
                    if (r_arg_idx != 2'd3) begin
                        w_next_idx = r_arg_idx + 2'd1;
                    end else begin
                        w_set_x      = 1'b1;
                        w_next_idx   = 2'd0;
                        w_next_state = w_need_y ? ST_CMD_Y : ST_CMD_W;
                    end
                end
            end
            ST_CMD_Y: begin
                if (w_done) begin
                    w_start      = 1'b1;
                    w_next_state = ST_ARG_Y;
                    w_next_idx   = 2'd0;
                end
            end
            ST_ARG_Y: begin
                if (w_done) begin
                    w_start = 1'b1;
                    if (r_arg_idx != 2'd3) begin
                        w_next_idx = r_arg_idx + 2'd1;
                    end else begin
                        w_set_y      = 1'b1;
                        w_next_idx   = 2'd0;
                        w_next_state = ST_CMD_W;
                    end
                end
            end
            ST_CMD_W: begin
                if (w_done) begin
                    w_start      = 1'b1;
                    w_next_state = ST_COL_H;
                end
            end
            ST_COL_H: begin
                if (w_done) begin
                    w_start      = 1'b1;
                    w_next_state = ST_COL_L;
                end
            end
            ST_COL_L: begin
                if (w_done) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // The byte launched on a start edge is the one belonging to the state being entered
    always_comb begin
        w_byte = 8'h00;
        w_dc   = 1'b1;
        case (w_next_state)
            ST_CMD_X: begin
                w_byte = CMD_CASET;
                w_dc   = 1'b0;
            end
            ST_ARG_X: w_byte = w_next_idx[0] ? r_work.x : 8'h00;
            ST_CMD_Y: begin
                w_byte = CMD_PASET;
                w_dc   = 1'b0;
            end
            ST_ARG_Y: w_byte = w_next_idx[0] ? r_work.y[7:0] : {7'b0, r_work.y[8]};
            ST_CMD_W: begin
                w_byte = CMD_RAMWR;
                w_dc   = 1'b0;
            end
            ST_COL_H: w_byte = r_work.color[15:8];
            ST_COL_L: w_byte = r_work.color[7:0];
            default: begin
                w_byte = 8'h00;
                w_dc   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_full <= 1'b0;
            r_hold      <= '0;
            r_work      <= '0;
            r_ack       <= 1'b0;
            r_state     <= ST_IDLE;
            r_arg_idx   <= 2'd0;
            r_last_x    <= 8'h00;
            r_last_y    <= 9'h000;
            r_xv        <= 1'b0;
            r_yv        <= 1'b0;
            r_cs_n      <= 1'b1;
        end else begin
            r_ack <= w_accept;
            // Clipped pixels are acked but never occupy the holding register
            if (w_accept) begin
                r_hold <= w_in_px;
                if (!w_clip) r_hold_full <= 1'b1;
            end else if ((r_state == ST_IDLE) && r_hold_full) begin
                r_hold_full <= 1'b0;
                r_work      <= r_hold;
            end
            r_state   <= w_next_state;
            r_arg_idx <= w_next_idx;
            if (w_set_x) begin
                r_xv     <= 1'b1;
                r_last_x <= r_work.x;
            end
            if (w_set_y) begin
                r_yv     <= 1'b1;
                r_last_y <= r_work.y;
            end
            if (w_start) begin
                r_cs_n <= 1'b0;
            end else if ((r_state == ST_COL_L) && w_done && !r_hold_full) begin
                r_cs_n <= 1'b1;
            end
        end
    end

    lcd_bus_byte #(
        .WR_LOW_CYC (WR_LOW_CYC),
        .WR_HIGH_CYC(WR_HIGH_CYC)
    ) u_bus_byte (
        .clock  (clock),
        .reset_n(reset_n),
        .i_start(w_start),
        .i_byte (w_byte),
        .i_dc   (w_dc),
        .o_d    (lcd_d_o),
        .o_dc   (lcd_dc_o),
        .o_wr_n (lcd_wr_n_o),
        .o_done (w_done)
    );

    assign px_ack_o   = r_ack;
    assign busy_o     = r_hold_full || (r_state != ST_IDLE);
    assign lcd_cs_n_o = r_cs_n;

endmodule
